saph_fpu_pipe: RTL and testbench
================================

// Module: saph_fpu_pipe
// PURPOSE
//   Fixed-latency, fully pipelined FPU that is the FPU-side responder of the saph_fpi protocol.
//   It accepts d_trig/d_lhs/d_rhs/d_mode from the GPU and returns q_trig/q_res exactly LATENCY
//   cycles later. It advertises its supported modes on has_modes.
//   It supports binary32 multiply, min/max and sign-injection, and sits behind an FPI connector.
// PARAMETERS
//   LATENCY  3  cycles from accepted d_trig to q_trig; legal range 1..8; GPU side must match
//   MODE_W   3  width of d_mode; has_modes is 2**MODE_W bits wide
// PORTS
//   clk        in   1         clock, all state on rising edge
//   rst_n      in   1         reset, asynchronous, active-low
//   d_trig     in   1         request valid; accepted when d_trig && d_ready
//   d_lhs      in   32        binary32 left operand
//   d_rhs      in   32        binary32 right operand
//   d_mode     in   MODE_W    operation select
//   d_ready    out  1         FPU can accept a request this cycle
//   q_trig     out  1         result valid, one-cycle pulse per accepted request
//   q_res      out  32        binary32 result, valid only while q_trig=1
//   has_modes  out  2**MODE_W bit n set = mode n supported; constant 8'h7F
// BEHAVIOUR
//   Reset values: d_ready=0, q_trig=0, q_res=0, all pipeline valid bits=0.
//     has_modes is constant and reset-independent.
//   d_ready: rises on the first clk edge after rst_n deasserts, then stays 1.
//     The pipeline never stalls: one request per cycle.
//   d_trig while d_ready=0: ignored; no q_trig is ever produced for it.
//   Request accepted at edge N -> q_trig=1 in the cycle after edge N+LATENCY-1, i.e. exactly
//     LATENCY cycles. Order is preserved. Back-to-back requests give back-to-back q_trig.
//   Datapath structure:
//     stage 1: unpack and classify; multiply 24x24 mantissas.
//     stage 2: normalise, round, pack.
//     remaining stages: delay only.
//     For LATENCY=1, all of this is combinational into a single register.
//   q_res holds 0 when q_trig=0; no stale data.
//   Modes (d_mode):
//     0 FMUL: see rules below.
//     1 FMIN: -0 < +0. If exactly one operand is NaN, return the other. If both are NaN, return 32'h7FC00000.
//     2 FMAX: mirror of FMIN.
//     3 FSGNJ:  {rhs[31], lhs[30:0]}
//     4 FSGNJN: {~rhs[31], lhs[30:0]}
//     5 FSGNJX: {lhs[31]^rhs[31], lhs[30:0]}
//     6 FABS:   {1'b0, lhs[30:0]}; rhs ignored
//     7 unsupported: still returns q_trig, with q_res=32'h7FC00000
//   FMUL rules:
//     - Sign = lhs[31]^rhs[31].
//     - Subnormal inputs are flushed to signed zero.
//     - Rounding is round-toward-zero (truncate the 48-bit product after normalisation).
//     - Exponent = ea+eb-127 (+1 if the product MSB is at bit 47). Compute in 10-bit signed.
//     - Exponent >= 255 -> signed 0x7F7FFFFF (RTZ overflow).
//     - Exponent <= 0 -> signed zero (flush-to-zero underflow).
//     - Any NaN input, or inf*0 -> 32'h7FC00000.
//     - inf*finite-nonzero or inf*inf -> signed infinity.
//     - zero*finite -> signed zero.
//   Reset mid-operation: all in-flight requests are discarded and q_trig drops immediately
//     (asynchronously). No result for them appears after rst_n rises.
//   Simultaneous accept and q_trig in the same cycle is normal pipelined operation; there is no interaction.
// TESTING
//   T1 FMUL 32'h40000000 * 32'h40400000 (2*3), LATENCY=3 -> q_trig exactly 3 cycles later, q_res=32'h40C00000
//   T2 three back-to-back requests: FMUL 1.0*1.5, FMIN 1.0/2.0, FABS 32'hBF800000
//      -> three consecutive q_trig cycles, in order: 32'h3FC00000, 32'h3F800000, 32'h3F800000
//   T3 FMIN(32'h80000000, 32'h00000000) -> 32'h80000000; FMAX(32'h7FC00001, 32'h3F800000) -> 32'h3F800000;
//      FMAX(NaN, NaN) -> 32'h7FC00000
//   T4 FMUL 32'h7F000000 * 32'h40800000 -> 32'h7F7FFFFF; 32'h7F800000 * 32'h00000000 -> 32'h7FC00000;
//      32'h00400000 (subnormal) * 32'h3F800000 -> 32'h00000000
//   T5 d_mode=7, operands 32'h3F800000/32'h3F800000 -> q_res=32'h7FC00000 after LATENCY cycles;
//      check has_modes==8'h7F; d_trig held high during reset -> no q_trig, d_ready=0
//   T6 two requests in flight, then pulse rst_n low -> q_trig=0 immediately;
//      after release, d_ready=1 next edge and no q_trig appears for LATENCY+2 cycles

Source files
------------

// File: rtl/saph_fpu_pipe.sv
// rtl/saph_fpu_pipe.sv - fixed-latency pipelined binary32 FPU, FPU-side responder of saph_fpi
//
// Purpose: accepts one request per cycle (d_trig/d_lhs/d_rhs/d_mode) and returns q_trig/q_res
//   exactly LATENCY cycles later, in order. Supports FMUL (RTZ, flush-to-zero), FMIN, FMAX,
//   FSGNJ, FSGNJN, FSGNJX and FABS. Unsupported modes return the canonical quiet NaN.
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   d_trig, d_ready         request valid / FPU ready; accepted when both are 1
//   d_lhs, d_rhs, d_mode    binary32 operands and operation select
//   q_trig, q_res           one-cycle result pulse and result (0 while q_trig=0)
//   has_modes               constant bitmap of supported modes

module saph_fpu_pipe #(
  parameter int LATENCY = 3,
  parameter int MODE_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   d_trig,
  input  logic [31:0]            d_lhs,
  input  logic [31:0]            d_rhs,
  input  logic [MODE_W-1:0]      d_mode,
  output logic                   d_ready,
  output logic                   q_trig,
  output logic [31:0]            q_res,
  output logic [2**MODE_W-1:0]   has_modes
);

  localparam int          N_MODES = 2**MODE_W;
  // Stage-2 register plus pure delay stages; LATENCY=1 folds everything into one register.
  localparam int          DEPTH   = (LATENCY == 1) ? 1 : LATENCY - 1;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  localparam logic [MODE_W-1:0] M_FMUL   = MODE_W'(0);
  localparam logic [MODE_W-1:0] M_FMIN   = MODE_W'(1);
  localparam logic [MODE_W-1:0] M_FMAX   = MODE_W'(2);
  localparam logic [MODE_W-1:0] M_FSGNJ  = MODE_W'(3);
  localparam logic [MODE_W-1:0] M_FSGNJN = MODE_W'(4);
  localparam logic [MODE_W-1:0] M_FSGNJX = MODE_W'(5);
  localparam logic [MODE_W-1:0] M_FABS   = MODE_W'(6);

  // Stage-1 result: either a finished value (direct) or a raw product still to normalise.
  typedef struct packed {
    logic               use_prod;
    logic               sign;
    logic signed [9:0]  exp;
    logic [47:0]        prod;
    logic [31:0]        direct;
  } s1_t;

  // Maps a binary32 onto an unsigned key whose order is the total order with -0 < +0.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  function automatic s1_t stage1(input logic [31:0] a, input logic [31:0] b,
                                 input logic [MODE_W-1:0] mode);
    s1_t               s;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [31:0]       ka, kb;
    logic [47:0]       ma, mb;
    logic signed [9:0] ea, eb;
    s      = '0;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    // Exponent field 0 covers both zero and subnormal: subnormals flush to zero.
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    ka     = order_key(a);
    kb     = order_key(b);
    ma     = {24'd0, 1'b1, a[22:0]};
    mb     = {24'd0, 1'b1, b[22:0]};
    ea     = {2'b00, a[30:23]};
    eb     = {2'b00, b[30:23]};
    case (mode)
      M_FMUL: begin
        s.sign = a[31] ^ b[31];
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf))
          s.direct = QNAN;
        else if (a_inf || b_inf)
          s.direct = {s.sign, 8'hFF, 23'd0};
        else if (a_zero || b_zero)
          s.direct = {s.sign, 31'd0};
        else begin
          s.use_prod = 1'b1;
          s.prod     = ma * mb;
          s.exp      = ea + eb - 10'sd127;
        end
      end
      M_FMIN: begin
        if (a_nan && b_nan) s.direct = QNAN;
        else if (a_nan)     s.direct = b;
        else if (b_nan)     s.direct = a;
        else                s.direct = (ka < kb) ? a : b;
      end
      M_FMAX: begin
        if (a_nan && b_nan) s.direct = QNAN;
        else if (a_nan)     s.direct = b;
        else if (b_nan)     s.direct = a;
        else                s.direct = (ka > kb) ? a : b;
      end
      M_FSGNJ:  s.direct = {b[31], a[30:0]};
      M_FSGNJN: s.direct = {~b[31], a[30:0]};
      M_FSGNJX: s.direct = {a[31] ^ b[31], a[30:0]};
      M_FABS:   s.direct = {1'b0, a[30:0]};
      default:  s.direct = QNAN;
    endcase
    return s;
  endfunction

  // Normalise, truncate (round-toward-zero), handle overflow/underflow and pack.
  function automatic logic [31:0] stage2(input s1_t s);
    logic signed [9:0] e;
    logic [22:0]       m;
    if (!s.use_prod) return s.direct;
    if (s.prod[47]) begin
      e = s.exp + 10'sd1;
      m = s.prod[46:24];
    end else begin
      e = s.exp;
      m = s.prod[45:23];
    end
    if (e >= 10'sd255)    return {s.sign, 31'h7F7FFFFF};
    else if (e <= 10'sd0) return {s.sign, 31'd0};
    else                  return {s.sign, e[7:0], m};
  endfunction

  logic        accept;
  s1_t         s1_comb;
  logic        s2_vld;
  logic [31:0] s2_res;
  logic        vld_p [DEPTH];
  logic [31:0] res_p [DEPTH];

  assign accept  = d_trig && d_ready;
  assign s1_comb = stage1(d_lhs, d_rhs, d_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_ready <= 1'b0;
    else        d_ready <= 1'b1;
  end

  generate
    if (LATENCY == 1) begin : g_single
      assign s2_vld = accept;
      assign s2_res = stage2(s1_comb);
    end else begin : g_split
      logic s1_vld;
      s1_t  s1_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_vld <= 1'b0;
          s1_q   <= '0;
        end else begin
          s1_vld <= accept;
          s1_q   <= accept ? s1_comb : '0;
        end
      end
      assign s2_vld = s1_vld;
      assign s2_res = stage2(s1_q);
    end
  endgenerate

  // Result is zeroed on entry for empty slots, so q_res is 0 whenever q_trig is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i] <= 1'b0;
        res_p[i] <= 32'd0;
      end
    end else begin
      vld_p[0] <= s2_vld;
      res_p[0] <= s2_vld ? s2_res : 32'd0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        res_p[i] <= res_p[i-1];
      end
    end
  end

  assign q_trig = vld_p[DEPTH-1];
  assign q_res  = res_p[DEPTH-1];

  always_comb begin
    has_modes = '0;
    for (int n = 0; n < N_MODES; n++) has_modes[n] = (n < 7);
  end

endmodule

// File: tb/tb_saph_fpu_pipe.sv
// tb/tb_saph_fpu_pipe.sv - directed self-checking bench for saph_fpu_pipe

module tb_saph_fpu_pipe;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        d_trig = 1'b0;
  logic [31:0] d_lhs = 32'd0;
  logic [31:0] d_rhs = 32'd0;
  logic [2:0]  d_mode = 3'd0;
  logic        d_ready;
  logic        q_trig;
  logic [31:0] q_res;
  logic [7:0]  has_modes;

  int n_cmp  = 0;
  int n_fail = 0;

  saph_fpu_pipe #(.LATENCY(LAT), .MODE_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d_trig    (d_trig),
    .d_lhs     (d_lhs),
    .d_rhs     (d_rhs),
    .d_mode    (d_mode),
    .d_ready   (d_ready),
    .q_trig    (q_trig),
    .q_res     (q_res),
    .has_modes (has_modes)
  );

  always #5 clk = ~clk;

  // Presents one request for exactly one rising edge, then withdraws it.
  task automatic issue(input logic [31:0] l, input logic [31:0] r, input logic [2:0] m);
    @(negedge clk);
    d_trig = 1'b1; d_lhs = l; d_rhs = r; d_mode = m;
    @(posedge clk);
    #1 d_trig = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
    n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL reset_q_trig got=%b exp=0", q_trig); end
    n_cmp++; if (q_res !== 32'd0) begin n_fail++; $display("FAIL reset_q_res got=%h exp=00000000", q_res); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b exp=1", d_ready); end
  endtask

  // T1: latency and value of a single multiply, plus zero result outside the pulse.
  task automatic test_fmul_basic;
    int n;
    issue(32'h40000000, 32'h40400000, 3'd0);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (q_trig !== 1'b1) begin
        n_cmp++; if (q_res !== 32'd0) begin n_fail++; $display("FAIL t1_idle_res cyc=%0d got=%h exp=00000000", n, q_res); end
      end
    end while (q_trig !== 1'b1 && n < 10);
    n_cmp++; if (n !== LAT) begin n_fail++; $display("FAIL t1_latency got=%0d exp=%0d", n, LAT); end
    n_cmp++; if (q_res !== 32'h40C00000) begin n_fail++; $display("FAIL t1_res got=%h exp=40C00000", q_res); end
    @(negedge clk);
    n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t1_pulse_width got=%b exp=0", q_trig); end
  endtask

  // T2: three consecutive accepts produce three consecutive results in order.
  task automatic test_back_to_back;
    logic [31:0] exp_res [3];
    exp_res[0] = 32'h3FC00000; exp_res[1] = 32'h3F800000; exp_res[2] = 32'h3F800000;
    @(negedge clk);
    d_trig = 1'b1; d_lhs = 32'h3F800000; d_rhs = 32'h3FC00000; d_mode = 3'd0;
    @(negedge clk);
    d_lhs = 32'h3F800000; d_rhs = 32'h40000000; d_mode = 3'd1;
    @(negedge clk);
    d_lhs = 32'hBF800000; d_rhs = 32'h00000000; d_mode = 3'd6;
    @(negedge clk);
    d_trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (q_trig !== 1'b1) begin n_fail++; $display("FAIL t2_trig[%0d] got=%b exp=1", i, q_trig); end
      n_cmp++; if (q_res !== exp_res[i]) begin n_fail++; $display("FAIL t2_res[%0d] got=%h exp=%h", i, q_res, exp_res[i]); end
      @(negedge clk);
    end
    n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t2_tail got=%b exp=0", q_trig); end
  endtask

  // T3 (min/max and signed zero / NaN rules) and T4 (multiply corner cases), one at a time.
  task automatic test_corner_ops;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [2:0]  vm [6];
    logic [31:0] ve [6];
    int n;
    va[0] = 32'h80000000; vb[0] = 32'h00000000; vm[0] = 3'd1; ve[0] = 32'h80000000;
    va[1] = 32'h7FC00001; vb[1] = 32'h3F800000; vm[1] = 3'd2; ve[1] = 32'h3F800000;
    va[2] = 32'h7FC00001; vb[2] = 32'hFF812345; vm[2] = 3'd2; ve[2] = 32'h7FC00000;
    va[3] = 32'h7F000000; vb[3] = 32'h40800000; vm[3] = 3'd0; ve[3] = 32'h7F7FFFFF;
    va[4] = 32'h7F800000; vb[4] = 32'h00000000; vm[4] = 3'd0; ve[4] = 32'h7FC00000;
    va[5] = 32'h00400000; vb[5] = 32'h3F800000; vm[5] = 3'd0; ve[5] = 32'h00000000;
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vm[i]);
      n = 0;
      do begin @(negedge clk); n++; end while (q_trig !== 1'b1 && n < 10);
      n_cmp++; if (n !== LAT) begin n_fail++; $display("FAIL corner_lat[%0d] got=%0d exp=%0d", i, n, LAT); end
      n_cmp++; if (q_res !== ve[i]) begin n_fail++; $display("FAIL corner_res[%0d] got=%h exp=%h", i, q_res, ve[i]); end
    end
  endtask

  // T5: unsupported mode, capability bitmap, and requests held during reset.
  task automatic test_mode7_and_reset_hold;
    int n;
    n_cmp++; if (has_modes !== 8'h7F) begin n_fail++; $display("FAIL has_modes got=%h exp=7F", has_modes); end
    issue(32'h3F800000, 32'h3F800000, 3'd7);
    n = 0;
    do begin @(negedge clk); n++; end while (q_trig !== 1'b1 && n < 10);
    n_cmp++; if (n !== LAT) begin n_fail++; $display("FAIL t5_lat got=%0d exp=%0d", n, LAT); end
    n_cmp++; if (q_res !== 32'h7FC00000) begin n_fail++; $display("FAIL t5_res got=%h exp=7FC00000", q_res); end
    @(negedge clk);
    rst_n = 1'b0;
    d_trig = 1'b1; d_lhs = 32'h40000000; d_rhs = 32'h40000000; d_mode = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL t5_hold_ready[%0d] got=%b exp=0", i, d_ready); end
      n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t5_hold_trig[%0d] got=%b exp=0", i, q_trig); end
    end
    n_cmp++; if (has_modes !== 8'h7F) begin n_fail++; $display("FAIL has_modes_in_reset got=%h exp=7F", has_modes); end
    rst_n = 1'b1;
    @(negedge clk);
    d_trig = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t5_ghost[%0d] got=%b exp=0", i, q_trig); end
    end
  endtask

  // T6: reset while one result is on the output and another is in flight.
  task automatic test_reset_mid_flight;
    @(negedge clk);
    d_trig = 1'b1; d_lhs = 32'h40000000; d_rhs = 32'h40400000; d_mode = 3'd0;
    @(negedge clk);
    d_lhs = 32'h3F800000; d_rhs = 32'h3FC00000;
    @(negedge clk);
    d_trig = 1'b0;
    @(negedge clk);
    n_cmp++; if (q_trig !== 1'b1) begin n_fail++; $display("FAIL t6_first_out got=%b exp=1", q_trig); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t6_async_drop got=%b exp=0", q_trig); end
    n_cmp++; if (q_res !== 32'd0) begin n_fail++; $display("FAIL t6_async_res got=%h exp=00000000", q_res); end
    n_cmp++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL t6_ready_low got=%b exp=0", d_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL t6_ready_back got=%b exp=1", d_ready); end
    n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t6_first_edge got=%b exp=0", q_trig); end
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      n_cmp++; if (q_trig !== 1'b0) begin n_fail++; $display("FAIL t6_ghost[%0d] got=%b exp=0", i, q_trig); end
    end
  endtask

  initial begin
    test_reset;
    test_fmul_basic;
    test_back_to_back;
    test_corner_ops;
    test_mode7_and_reset_hold;
    test_reset_mid_flight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
